// File: rtl/data_memory_pkg.sv
// Shared load/store encodings for the core decoder and the data memory.
package data_memory_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    // Unsigned forms only exist for loads, so they are illegal on a store.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
        case (f3)
            LS_B, LS_H, LS_W: return 1'b0;
            LS_BU, LS_HU:     return wr;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Lane select plus sign/zero extension of a raw memory word for loads.
module data_memory_load_extend
    import data_memory_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(i_word >> {i_offset, 3'b000});
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        case (i_funct3)
            LS_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LS_H:    o_data = {{16{w_half[15]}}, w_half};
            LS_BU:   o_data = {24'h0, w_byte};
            LS_HU:   o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-lane-writable word memory with asynchronous extended loads and a
// sticky fault flag for suppressed (misaligned/out-of-range/illegal) accesses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        AccessFault
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              r_fault;

    logic [AW-1:0]     w_idx;
    logic [1:0]        w_off;
    logic              w_out_of_range;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_bad;
    logic              w_store;
    logic [LANES-1:0]  w_be;
    logic [31:0]       w_wlane;
    logic [31:0]       w_ext;

    assign w_idx = Address[AW+1:2];
    assign w_off = Address[1:0];

    // Access classification; size comes from Funct3[1:0] (00 byte, 01 half, 10 word).
    always_comb begin
        w_out_of_range = |(Address >> (AW + 2));
        w_misaligned   = 1'b0;
        w_be           = '0;
        w_wlane        = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                w_be    = 4'(4'b0001 << w_off);
                w_wlane = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_misaligned = w_off[0];
                w_be         = 4'(4'b0011 << w_off);
                w_wlane      = {2{WriteData[15:0]}};
            end
            2'b10: begin
                w_misaligned = (w_off != 2'b00);
                w_be         = 4'b1111;
            end
            default: begin
                w_be = '0;
            end
        endcase
        w_illegal = f3_illegal(Funct3, MemWrite);
        w_bad     = (MemRead | MemWrite) & (w_out_of_range | w_misaligned | w_illegal);
        w_store   = MemWrite & ~w_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_bad) begin
            r_fault <= 1'b1;
        end
    end

    data_memory_load_extend u_load_extend (
        .i_word   (r_mem[w_idx]),
        .i_offset (w_off),
        .i_funct3 (Funct3),
        .o_data   (w_ext)
    );

    assign ReadData    = (MemRead && !w_bad) ? w_ext : 32'h0;
    assign AccessFault = r_fault;

endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory with hand-computed expectations.
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  Funct3;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        AccessFault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .Funct3      (Funct3),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .AccessFault (AccessFault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an access, then let combinational outputs settle.
    task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemWrite  = we;
        MemRead   = re;
        Funct3    = f3;
        Address   = addr;
        WriteData = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, LS_W, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b1, 1'b0, f3, addr, wd);
        tick();
        idle();
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, 1'b1, f3, addr, 32'h0);
        check(tag, ReadData, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Store presented during reset must be discarded.
        drive(1'b1, 1'b0, LS_W, 32'h40, 32'hFFFF_FFFF);
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        check("reset_fault", 32'(AccessFault), 32'h0);
        load_chk("reset_lw0", LS_W, 32'h00, 32'h0);
        load_chk("reset_store_discarded", LS_W, 32'h40, 32'h0);

        store(LS_W, 32'h10, 32'hDEAD_BEEF);
        load_chk("lw_10",  LS_W,  32'h10, 32'hDEAD_BEEF);
        load_chk("lb_13",  LS_B,  32'h13, 32'hFFFF_FFDE);
        load_chk("lbu_13", LS_BU, 32'h13, 32'h0000_00DE);
        load_chk("lh_12",  LS_H,  32'h12, 32'hFFFF_DEAD);
        load_chk("lhu_10", LS_HU, 32'h10, 32'h0000_BEEF);
        load_chk("lb_10",  LS_B,  32'h10, 32'hFFFF_FFEF);
        load_chk("lh_10",  LS_H,  32'h10, 32'hFFFF_BEEF);
        load_chk("lbu_11", LS_BU, 32'h11, 32'h0000_00BE);

        store(LS_B, 32'h11, 32'h0000_005A);
        load_chk("sb_11", LS_W, 32'h10, 32'hDEAD_5AEF);
        store(LS_H, 32'h12, 32'hFFFF_1234);
        load_chk("sh_12", LS_W, 32'h10, 32'h1234_5AEF);
        drive(1'b0, 1'b0, LS_W, 32'h10, 32'h0);
        check("no_read_zero", ReadData, 32'h0);
        check("fault_clean", 32'(AccessFault), 32'h0);

        // Same-cycle store and load: old data now, new data next cycle.
        store(LS_W, 32'h40, 32'hAAAA_AAAA);
        drive(1'b1, 1'b1, LS_W, 32'h40, 32'h1111_1111);
        check("rw_same_cycle", ReadData, 32'hAAAA_AAAA);
        tick();
        load_chk("rw_next_cycle", LS_W, 32'h40, 32'h1111_1111);

        // Misaligned word store is suppressed; fault rises only after the edge.
        store(LS_W, 32'h20, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, LS_W, 32'h22, 32'h1234_5678);
        check("fault_not_comb", 32'(AccessFault), 32'h0);
        tick();
        idle();
        check("fault_after_mis", 32'(AccessFault), 32'h1);
        load_chk("mis_store_kept", LS_W, 32'h20, 32'hCAFE_F00D);
        load_chk("mis_store_kept_hi", LS_W, 32'h24, 32'h0);
        load_chk("mis_lw_zero", LS_W, 32'h22, 32'h0);
        load_chk("mis_lh_zero", LS_H, 32'h11, 32'h0);
        tick();
        store(LS_W, 32'h30, 32'h0000_0001);
        check("fault_sticky", 32'(AccessFault), 32'h1);

        do_reset();
        check("fault_cleared", 32'(AccessFault), 32'h0);
        load_chk("mem_cleared", LS_W, 32'h10, 32'h0);

        // Out-of-range load at DEPTH*4.
        drive(1'b0, 1'b1, LS_W, 32'h400, 32'h0);
        check("oor_lw_zero", ReadData, 32'h0);
        check("oor_not_comb", 32'(AccessFault), 32'h0);
        tick();
        idle();
        check("oor_fault", 32'(AccessFault), 32'h1);

        // Out-of-range store must not alias onto a low word.
        do_reset();
        store(LS_W, 32'h410, 32'h0000_0077);
        load_chk("oor_no_alias", LS_W, 32'h10, 32'h0);
        check("oor_store_fault", 32'(AccessFault), 32'h1);

        // Unsigned code on a store is illegal and suppressed.
        do_reset();
        store(LS_BU, 32'h10, 32'h0000_0099);
        load_chk("sbu_no_write", LS_W, 32'h10, 32'h0);
        check("sbu_fault", 32'(AccessFault), 32'h1);

        // Reserved funct3 on a load returns zero and faults.
        do_reset();
        store(LS_W, 32'h10, 32'h1357_9BDF);
        load_chk("f3_011_zero", 3'b011, 32'h10, 32'h0);
        tick();
        idle();
        check("f3_011_fault", 32'(AccessFault), 32'h1);
        load_chk("legal_after_fault", LS_W, 32'h10, 32'h1357_9BDF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the single-cycle RISC-V core, directly downstream of the ALU: it takes the ALU result as a byte address and performs the load or store named by the instruction's funct3. Stores commit on the clock edge; loads read asynchronously, so the write-back mux gets load data in the same cycle. Misaligned and out-of-range accesses are suppressed and latched into a sticky fault flag that the core can expose for debug.

## Interface

- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- AW, log2(DEPTH): word-index width, derived; not overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- MemWrite  in  1  store enable for the current instruction.
- MemRead  in  1  load enable for the current instruction.
- Funct3  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; others illegal.
- Address  in  32  byte address, driven by the ALU result.
- WriteData  in  32  store data, least-significant bytes used for byte/half.
- ReadData  out  32  extended load result.
- AccessFault  out  1  sticky: set by any suppressed access, cleared only by reset.

## Operation

- Word index = Address[AW+1:2]; byte offset = Address[1:0].
- Out of range: any of Address[31:AW+2] nonzero.
- Misaligned: half with offset[0]=1; word with offset≠00.
- Illegal: Funct3 outside the five legal codes while MemRead or MemWrite is 1; unsigned codes with MemWrite.
- Bad access = (MemRead|MemWrite) & (out of range | misaligned | illegal).
- Store (MemWrite=1, not bad): byte enables from size and offset. Byte writes WriteData[7:0] into lane offset. Half writes WriteData[15:0] into lanes offset..offset+1. Word writes all four lanes. Unenabled lanes are unchanged.
- Load (MemRead=1, not bad): select lane(s) by offset, then sign-extend (000, 001) or zero-extend (100, 101). A word load returns the word unchanged.
- ReadData = 0 when MemRead=0 or the access is bad.
- MemRead and MemWrite both 1: the store commits at the edge; ReadData shows pre-store contents.
- Bad store: no lane is written. AccessFault is set at the next edge.
- AccessFault is set by any bad access on an edge where rst_n=1, and holds until rst_n=0.

## Timing

- Reset: on a rising edge with rst_n=0, every word is cleared to 0 and AccessFault goes to 0. A store presented in the same cycle is discarded. Reset takes priority over everything.
- Reset values: AccessFault=0. ReadData=0 for any legal load after reset.
- Store latency: commits at the rising edge that ends the instruction's cycle and is visible to a load in the next cycle.
- Load latency: zero cycles. ReadData is combinational from Address, Funct3, MemRead and array contents.
- A load in the same cycle as a store to the same word returns old data; there is no bypass.
- AccessFault rises one edge after the bad access and is never combinational.

## Structure

- Shared package: Funct3 load/store encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU). The core control decoder already uses these, so they live in the package and are not redefined locally.
- One natural sub-module, load_extend: purely combinational. Inputs: raw word, offset, Funct3. Output: the extended 32-bit value.
- Store byte-enable generation and the fault register stay in data_memory.
- Array: DEPTH×32 register array, written per byte lane.

## Test plan

- Reset, then word load at 0x00 → ReadData=0x00000000, AccessFault=0.
- Store sw 0xDEADBEEF at 0x10, then lb at 0x13, lbu at 0x13, lh at 0x12, lhu at 0x10 → 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF.
- Store sb 0x5A at 0x11 over 0xDEADBEEF, then lw 0x10 → 0xDEAD5AEF.
- Store sw 0x12345678 at 0x22 (misaligned), then lw 0x20 → word at 0x20 unchanged, AccessFault=1 from the next edge. AccessFault stays 1 across further legal accesses until reset.
- Load at byte address DEPTH*4 → ReadData=0 and AccessFault set. Store with rst_n=0 in the same cycle → contents stay 0 after reset.
- Same-cycle store 0x11111111 and load at 0x40, prior content 0xAAAAAAAA → ReadData=0xAAAAAAAA that cycle, 0x11111111 the next cycle.
